// File: rtl/npu_core.sv
// npu_core: single-neuron dot-product engine (sum(w*x)+bias) behind config, input and output FIFOs.
// Build option NPU_SATURATE_EN: clamp results to the signed 32-bit range instead of wrapping.

module npu_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          empty_q, full_q, push_ok, pop_ok;

  // Head is registered so it holds its last value once the FIFO drains.
  always_comb begin
    pop_ok  = pop_i && !empty_q;
    push_ok = push_i && (!full_q || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    head_d  = head_q;
    if (push_ok) begin
      wr_d  = wr_q + AW'(1);
      cnt_d = cnt_d + (AW+1)'(1);
    end
    if (pop_ok) begin
      rd_d  = rd_q + AW'(1);
      cnt_d = cnt_d - (AW+1)'(1);
    end
    if (cnt_d != '0) head_d = (push_ok && (wr_q == rd_d)) ? wdata_i : mem_q[rd_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      head_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      empty_q <= (cnt_d == '0);
      full_q  <= (cnt_d == FULL_CNT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  assign head_o  = head_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;
endmodule

module npu_core #(
  parameter int CFG_DEPTH = 16,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  parameter int MAX_N     = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] npu_input_data,
  input  logic        npu_input_fifo_write_enable,
  input  logic [25:0] npu_config_data,
  input  logic        npu_config_fifo_write_enable,
  input  logic        npu_output_fifo_read_enable,
  output logic [31:0] npu_output_data,
  output logic        npu_output_fifo_empty,
  output logic        npu_input_fifo_full,
  output logic        npu_config_fifo_full
);
  localparam int WAW = $clog2(MAX_N);
  localparam int NW  = WAW + 1;
  localparam logic [NW-1:0] MAX_NV = NW'(MAX_N);
  localparam logic [7:0]    MAX_N8 = 8'(MAX_N);

  typedef enum logic [1:0] {IDLE, ACCUM, WRITE} state_e;

  state_e             state_q;
  logic [NW-1:0]      n_q, idx_q, wptr_q, n_set;
  logic signed [23:0] bias_q;
  logic signed [47:0] acc_q, prod, bias_ext;
  logic signed [15:0] w_mem_q [MAX_N];
  logic signed [15:0] w_cur;
  logic signed [31:0] x_cur;
  logic [25:0]        cfg_head;
  logic [31:0]        in_head, result;
  logic [1:0]         op;
  logic [23:0]        payload;
  logic               cfg_empty, in_empty, out_full, out_empty;
  logic               cfg_pop, in_pop, out_push, out_accept;

  npu_fifo #(.W(26), .DEPTH(CFG_DEPTH)) u_cfg_fifo (
    .clk_i(CLK), .rst_i(RST), .push_i(npu_config_fifo_write_enable), .wdata_i(npu_config_data),
    .pop_i(cfg_pop), .head_o(cfg_head), .empty_o(cfg_empty), .full_o(npu_config_fifo_full)
  );

  npu_fifo #(.W(32), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i(CLK), .rst_i(RST), .push_i(npu_input_fifo_write_enable), .wdata_i(npu_input_data),
    .pop_i(in_pop), .head_o(in_head), .empty_o(in_empty), .full_o(npu_input_fifo_full)
  );

  npu_fifo #(.W(32), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i(CLK), .rst_i(RST), .push_i(out_push), .wdata_i(result),
    .pop_i(npu_output_fifo_read_enable), .head_o(npu_output_data), .empty_o(out_empty),
    .full_o(out_full)
  );

  assign npu_output_fifo_empty = out_empty;
  assign op      = cfg_head[25:24];
  assign payload = cfg_head[23:0];
  assign n_set   = (payload[7:0] > MAX_N8) ? MAX_NV : NW'(payload[7:0]);
  assign cfg_pop = (state_q == IDLE) && !cfg_empty;
  assign in_pop  = (state_q == ACCUM) && !in_empty;
  assign out_push = (state_q == WRITE);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the result.
  assign out_accept = !out_full || (npu_output_fifo_read_enable && !out_empty);

  assign x_cur    = in_head;
  assign w_cur    = w_mem_q[idx_q[WAW-1:0]];
  assign prod     = 48'(x_cur) * 48'(w_cur);
  assign bias_ext = 48'(bias_q);

  always_comb begin
    result = 32'((acc_q + (bias_ext <<< 8)) >>> 8);
`ifdef NPU_SATURATE_EN
    if (((acc_q + (bias_ext <<< 8)) >>> 8) > 48'sh0000_7FFF_FFFF) result = 32'h7FFF_FFFF;
    else if (((acc_q + (bias_ext <<< 8)) >>> 8) < -48'sh0000_8000_0000) result = 32'h8000_0000;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wptr_q  <= '0;
      bias_q  <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!cfg_empty) begin
            case (op)
              2'b01: begin
                n_q    <= n_set;
                wptr_q <= '0;
              end
              2'b10: if (wptr_q < MAX_NV) wptr_q <= wptr_q + NW'(1);
              2'b11: bias_q <= payload;
              default: ;
            endcase
          end else if (!in_empty && (n_q != '0)) begin
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (!in_empty) begin
            acc_q <= acc_q + prod;
            idx_q <= idx_q + NW'(1);
            if ((idx_q + NW'(1)) == n_q) state_q <= WRITE;
          end
        end
        WRITE: if (out_accept) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Weight table has no reset; entries past the table end are silently dropped.
  always_ff @(posedge CLK) begin
    if (cfg_pop && (op == 2'b10) && (wptr_q < MAX_NV)) w_mem_q[wptr_q[WAW-1:0]] <= payload[15:0];
  end
endmodule

// File: tb/tb_npu_core.sv
// Scoreboard bench for npu_core: a queue-based neuron model predicts each result, a monitor pops and compares.
module tb_npu_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_we = 1'b0;
  logic [25:0] cfg_data = '0;
  logic        cfg_we = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] out_data;
  logic        out_empty, in_full, cfg_full;

  always #5 clk = ~clk;

  npu_core dut (
    .CLK(clk), .RST(rst),
    .npu_input_data(in_data), .npu_input_fifo_write_enable(in_we),
    .npu_config_data(cfg_data), .npu_config_fifo_write_enable(cfg_we),
    .npu_output_fifo_read_enable(rd_en), .npu_output_data(out_data),
    .npu_output_fifo_empty(out_empty), .npu_input_fifo_full(in_full),
    .npu_config_fifo_full(cfg_full)
  );

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_prob = 0;

  // Reference neuron: configuration registers plus the inputs not yet folded into a result.
  int          m_n = 0;
  int          m_wptr = 0;
  longint      m_bias = 0;
  logic [15:0] m_w[64];
  logic [31:0] m_pend[$];
  logic [15:0] cfg_w_q[$];

  function automatic logic [31:0] model_result(input longint acc, input longint bias);
    longint s;
    s = (acc + bias * 256) >>> 8;
`ifdef NPU_SATURATE_EN
    if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  function automatic void model_drain();
    longint acc;
    while (m_n > 0 && m_pend.size() >= m_n) begin
      acc = 0;
      for (int i = 0; i < m_n; i++)
        acc += longint'(signed'(m_pend[i])) * longint'(signed'(m_w[i]));
      acc = (acc <<< 16) >>> 16;
      for (int i = 0; i < m_n; i++) void'(m_pend.pop_front());
      exp_q.push_back(model_result(acc, m_bias));
    end
  endfunction

  function automatic void model_cfg(input logic [1:0] op, input logic [23:0] p);
    case (op)
      2'b01: begin
        m_n    = (p[7:0] > 8'd64) ? 64 : int'(p[7:0]);
        m_wptr = 0;
        model_drain();
      end
      2'b10: if (m_wptr < 64) begin
        m_w[m_wptr] = p[15:0];
        m_wptr++;
      end
      2'b11: m_bias = longint'(signed'(p));
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    m_pend.delete();
    m_n = 0; m_wptr = 0; m_bias = 0;
  endtask

  task automatic cfg_write(input logic [1:0] op, input logic [23:0] p);
    int g = 0;
    @(negedge clk);
    while (cfg_full && g < 1000) begin @(negedge clk); g++; end
    if (cfg_full) begin
      checks++; errors++;
      $display("FAIL cfg_write: config FIFO stayed full, got full=1, expected 0");
      return;
    end
    cfg_data = {op, p};
    cfg_we = 1'b1;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    model_cfg(op, p);
  endtask

  task automatic in_write(input logic [31:0] x, input bit force_w);
    int g = 0;
    bit acc;
    @(negedge clk);
    while (!force_w && in_full && g < 1000) begin @(negedge clk); g++; end
    if (!force_w && in_full) begin
      checks++; errors++;
      $display("FAIL in_write: input FIFO stayed full, got full=1, expected 0");
      return;
    end
    acc = !in_full;
    in_data = x;
    in_we = 1'b1;
    @(posedge clk);
    #1 in_we = 1'b0;
    if (acc) begin
      m_pend.push_back(x);
      model_drain();
    end
  endtask

  // SET_N 0 first so no group starts while weights are still being loaded.
  task automatic config_neuron(input logic [7:0] n, input logic [23:0] b);
    cfg_write(2'b01, 24'd0);
    foreach (cfg_w_q[i]) cfg_write(2'b10, {8'h00, cfg_w_q[i]});
    cfg_write(2'b11, b);
    cfg_write(2'b01, {16'h0, n});
  endtask

  task automatic wait_nonempty(input string name);
    int g = 0;
    while (out_empty && g < 2000) begin @(negedge clk); g++; end
    check(name, {31'b0, out_empty}, 32'd0);
  endtask

  task automatic wait_drain(input string name);
    int g = 0;
    while ((exp_q.size() != 0 || !out_empty) && g < 5000) begin @(negedge clk); g++; end
    checks++;
    if (g >= 5000) begin
      errors++;
      $display("FAIL %s: drain timeout, got %0d results outstanding, expected 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: decides reads at the falling edge and checks the head that the next rising edge pops.
  initial begin
    forever begin
      @(negedge clk);
      rd_en = 1'b0;
      if (!rst && !out_empty && rd_prob > 0 && $urandom_range(99) < rd_prob) begin
        rd_en = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL output: got unexpected result 0x%08h, expected none", out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (out_data !== e) begin
            errors++;
            $display("FAIL output: got 0x%08h, expected 0x%08h", out_data, e);
          end
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    foreach (m_w[i]) m_w[i] = '0;

    // Reset values
    do_reset();
    @(negedge clk);
    check("reset_out_empty", {31'b0, out_empty}, 32'd1);
    check("reset_in_full", {31'b0, in_full}, 32'd0);
    check("reset_cfg_full", {31'b0, cfg_full}, 32'd0);
    check("reset_out_data", out_data, 32'd0);

    // Basic neuron: 2*1.0 + 3*2.0 + 5 = 13
    rd_prob = 0;
    cfg_w_q = '{16'h0100, 16'h0200};
    config_neuron(8'd2, 24'd5);
    in_write(32'd2, 1'b0);
    in_write(32'd3, 1'b0);
    wait_nonempty("basic_nonempty");
    check("basic_head", out_data, 32'h0000_000D);
    rd_prob = 100;
    wait_drain("basic_drain");
    check("basic_empty_after_read", {31'b0, out_empty}, 32'd1);
    check("basic_hold_after_empty", out_data, 32'h0000_000D);

    // Stream: same configuration, eight operands of 3 -> four results of 14
    for (int i = 0; i < 8; i++) in_write(32'd3, 1'b0);
    wait_drain("stream_drain");

    // Back-pressure: 16 results fill the output, one waits in WRITE, 16 operands fill the input
    cfg_w_q = '{16'h0100};
    config_neuron(8'd1, 24'd0);
    rd_prob = 0;
    for (int i = 0; i < 33; i++) in_write(32'd7, 1'b0);
    repeat (20) @(negedge clk);
    check("bp_in_full", {31'b0, in_full}, 32'd1);
    check("bp_out_nonempty", {31'b0, out_empty}, 32'd0);
    rd_prob = 100;
    wait_drain("bp_drain");

    // Full input FIFO with N=0: write 17 is dropped
    do_reset();
    rd_prob = 0;
    for (int i = 0; i < 17; i++) begin
      in_write(32'd100 + 32'(i), 1'b1);
      if (i == 14) check("full_after_15", {31'b0, in_full}, 32'd0);
      if (i == 15) check("full_after_16", {31'b0, in_full}, 32'd1);
      if (i == 16) check("full_after_17", {31'b0, in_full}, 32'd1);
    end
    cfg_w_q = '{16'h0100};
    config_neuron(8'd1, 24'd0);
    rd_prob = 100;
    wait_drain("full_drain");
    repeat (10) @(negedge clk);
    check("full_no_extra", {31'b0, out_empty}, 32'd1);

    // Saturation / wrap at both extremes
    cfg_w_q = '{16'h7FFF};
    config_neuron(8'd1, 24'd0);
    in_write(32'h7FFF_FFFF, 1'b0);
    wait_drain("sat_pos");
    cfg_w_q = '{16'h8000};
    config_neuron(8'd1, 24'd0);
    in_write(32'h7FFF_FFFF, 1'b0);
    wait_drain("sat_neg");

    // N clipped to 64; a 65th weight must not disturb entry 0
    cfg_w_q.delete();
    for (int i = 0; i < 64; i++) cfg_w_q.push_back(16'h0100);
    cfg_w_q.push_back(16'h7FFF);
    config_neuron(8'd200, 24'hFFFFF0);
    for (int i = 0; i < 64; i++) in_write(32'($urandom_range(0, 1000)), 1'b0);
    wait_drain("clip_drain");

    // Randomized neurons with random read pressure
    for (int t = 0; t < 6; t++) begin
      int n, groups;
      n = $urandom_range(1, 8);
      groups = $urandom_range(1, 4);
      cfg_w_q.delete();
      for (int i = 0; i < n; i++) cfg_w_q.push_back(16'($urandom_range(0, 65535)));
      config_neuron(8'(n), 24'($urandom));
      rd_prob = $urandom_range(20, 100);
      for (int i = 0; i < n * groups; i++) begin
        r = $urandom;
        in_write({{2{r[29]}}, r[29:0]}, 1'b0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      if (rd_prob < 100) rd_prob = 100;
      wait_drain("rand_drain");
    end

    // Reset mid-operation discards results, queued operands and configuration
    rd_prob = 0;
    cfg_w_q = '{16'h0100};
    config_neuron(8'd1, 24'd0);
    for (int i = 0; i < 3; i++) in_write(32'd9, 1'b0);
    repeat (15) @(negedge clk);
    check("midrst_before", {31'b0, out_empty}, 32'd0);
    do_reset();
    @(negedge clk);
    check("midrst_out_empty", {31'b0, out_empty}, 32'd1);
    check("midrst_out_data", out_data, 32'd0);
    rd_prob = 100;
    in_write(32'd9, 1'b0);
    repeat (20) @(negedge clk);
    check("midrst_n_cleared", {31'b0, out_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
